// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, thresholds and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module fifo_sync_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = (2 ** ADDR_W) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  output logic              fifoFull,
  output logic              fifoEmpty,
  output logic              almostFull,
  output logic              almostEmpty,
  output logic [ADDR_W:0]   fifoCount,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  wrPtr;
  logic [CNT_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] wrAddr;
  logic [ADDR_W-1:0] rdAddr;
  logic              wrAcc;
  logic              rdAcc;

  assign wrAddr = wrPtr[ADDR_W-1:0];
  assign rdAddr = rdPtr[ADDR_W-1:0];

  assign fifoCount   = count;
  assign fifoFull    = (count == FULL_CNT);
  assign fifoEmpty   = (count == '0);
  assign almostFull  = (count >= AFULL_CNT);
  assign almostEmpty = (count <= AEMPTY_CNT);

  // A read frees a slot in the same edge, so a full FIFO still takes a write
  assign rdAcc = rdEn && !fifoEmpty;
  assign wrAcc = wrEn && (!fifoFull || rdAcc);

  always_ff @(posedge clk) begin
    if (wrAcc) begin
      mem[wrAddr] <= wrData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wrAcc) begin
        wrPtr <= wrPtr + ONE;
      end
      if (rdAcc) begin
        rdPtr <= rdPtr + ONE;
      end
      unique case (1'b1)
        (wrAcc && !rdAcc): count <= count + ONE;
        (rdAcc && !wrAcc): count <= count - ONE;
        default:           count <= count;
      endcase
      overflow  <= wrEn && !wrAcc;
      underflow <= rdEn && !rdAcc;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown directly; forced to zero while nothing is stored
  assign rdData  = fifoEmpty ? '0 : mem[rdAddr];
  assign rdValid = !fifoEmpty;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdData  <= '0;
      rdValid <= 1'b0;
    end else begin
      rdValid <= rdAcc;
      if (rdAcc) begin
        rdData <= mem[rdAddr];
      end
    end
  end
`endif

endmodule
